// File: rtl/code_event_stamper.sv
// code_event_stamper
//   Stamps single-cycle event strobes with the current code count and the
//   event ID, buffers the stamps in a DEPTH-entry FIFO and presents them to
//   the readout over a valid/ready interface. When the FIFO is full, events
//   are dropped. Each drop sets a sticky overflow flag and increments a
//   saturating drop counter.
//
//   Optional build macro CODE_STAMP_DELTA_EN: when defined, the stamp field
//   holds the count difference to the previously accepted event instead of
//   the absolute count.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   count_in    code count (changes on falling edge, stable at rising edge)
//   evt_valid   single-cycle event strobe
//   evt_id      event identifier, valid with evt_valid
//   ts_valid    head entry available
//   ts_ready    consumer accepts head entry
//   ts_data     head entry {evt_id, stamp}
//   level       number of stored entries (0..DEPTH)
//   overflow    sticky: an event was dropped
//   drop_count  dropped-event counter, saturates at 255
//   clr_ovf     clears overflow and drop_count (a same-cycle drop wins)
module code_event_stamper #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32,
  parameter int ID_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CNT_W-1:0]            count_in,
  input  logic                        evt_valid,
  input  logic [ID_W-1:0]             evt_id,
  output logic                        ts_valid,
  input  logic                        ts_ready,
  output logic [CNT_W+ID_W-1:0]       ts_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  output logic [7:0]                  drop_count,
  input  logic                        clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = CNT_W + ID_W;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] stamp;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    empty = (level == '0);
    full  = (level == LVL_FULL);
    pop   = !empty && ts_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push  = evt_valid && (!full || pop);
    drop  = evt_valid && full && !pop;
  end

`ifdef CODE_STAMP_DELTA_EN
  // Reset value 0 makes the first accepted event store its absolute count.
  logic [CNT_W-1:0] prev_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prev_count <= '0;
    else if (push)
      prev_count <= count_in;
  end

  assign stamp = count_in - prev_count;
`else
  assign stamp = count_in;
`endif

  // Storage is not reset; level gates every read, so stale entries are
  // never presented.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {evt_id, stamp};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf)
          drop_count <= 8'd1;
        else if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (clr_ovf) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  always_comb begin
    ts_valid = !empty;
    ts_data  = ts_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_code_event_stamper.sv
// Scoreboard bench for code_event_stamper: expected entries are queued as
// events are driven and compared against the head while the DUT holds them.
module tb_code_event_stamper;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] count_in;
  logic        evt_valid;
  logic [3:0]  evt_id;
  logic        ts_valid;
  logic        ts_ready;
  logic [35:0] ts_data;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clr_ovf;

  code_event_stamper #(.DEPTH(DEPTH), .CNT_W(32), .ID_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
    .ts_valid   (ts_valid),
    .ts_ready   (ts_ready),
    .ts_data    (ts_data),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [35:0] sb[$];
  int          m_level = 0;
  logic        m_ovf   = 1'b0;
  logic [7:0]  m_dc    = '0;
  logic [31:0] m_prev  = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_level = 0;
    m_ovf   = 1'b0;
    m_dc    = '0;
    m_prev  = '0;
  endtask

  // Called #1 after a rising edge: drives one cycle of stimulus, updates the
  // model, then checks the DUT #1 after the next rising edge.
  task automatic cycle(input logic ev, input logic [3:0] id, input logic [31:0] cnt,
                       input logic rdy, input logic clr);
    logic        pop, push, drop;
    logic [31:0] st;
    evt_valid = ev;
    evt_id    = id;
    count_in  = cnt;
    ts_ready  = rdy;
    clr_ovf   = clr;
    pop  = (m_level > 0) && rdy;
    push = ev && ((m_level < DEPTH) || pop);
    drop = ev && !push;
    if (pop) begin
      sb.delete(0);
      m_level--;
    end
    if (push) begin
`ifdef CODE_STAMP_DELTA_EN
      st     = cnt - m_prev;
      m_prev = cnt;
`else
      st = cnt;
`endif
      sb.push_back({id, st});
      m_level++;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (clr)                m_dc = 8'd1;
      else if (m_dc != 8'hFF) m_dc = m_dc + 8'd1;
    end else if (clr) begin
      m_ovf = 1'b0;
      m_dc  = '0;
    end
    @(posedge clk);
    #1;
    evt_valid = 1'b0;
    ts_ready  = 1'b0;
    clr_ovf   = 1'b0;
    check_eq("level", 64'(level), 64'(m_level));
    check_eq("ts_valid", 64'(ts_valid), 64'(m_level != 0));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("drop_count", 64'(drop_count), 64'(m_dc));
    if (sb.size() > 0)
      check_eq("head", 64'(ts_data), 64'(sb[0]));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ts_valid"}, 64'(ts_valid), 64'd0);
    check_eq({tag, "_level"}, 64'(level), 64'd0);
    check_eq({tag, "_overflow"}, 64'(overflow), 64'd0);
    check_eq({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    check_eq({tag, "_ts_data"}, 64'(ts_data), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    count_in  = '0;
    evt_valid = 1'b0;
    evt_id    = '0;
    ts_ready  = 1'b0;
    clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b0;
    model_reset();

    // Single event: count 100, id 3, then drain.
    cycle(1'b1, 4'h3, 32'd100, 1'b0, 1'b0);
    check_eq("single_data", 64'(ts_data), 64'({4'h3, 32'd100}));
    cycle(1'b0, 4'h0, 32'd101, 1'b1, 1'b0);

    // Ready on an empty FIFO must not move the read pointer.
    cycle(1'b0, 4'h0, 32'd102, 1'b1, 1'b0);

    // Backpressure: fill with 10..17, drop 18, drain.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 4'(i), 32'(10 + i), 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 32'd18, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 4'h0, 32'd19, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 32'd19, 1'b0, 1'b1);

    // Full with simultaneous push and pop: 50 becomes the last entry.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 4'(i + 2), 32'(20 + i), 1'b0, 1'b0);
    cycle(1'b1, 4'hA, 32'd50, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 4'h0, 32'd51, 1'b1, 1'b0);

    // Drop coincident with clr_ovf: drop wins; clr alone then clears.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 4'h5, 32'(60 + i), 1'b0, 1'b0);
    cycle(1'b1, 4'h6, 32'd70, 1'b0, 1'b0);
    cycle(1'b1, 4'h6, 32'd71, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 32'd72, 1'b0, 1'b1);

    // Saturation of drop_count at 255.
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 4'h7, 32'(100 + i), 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 4'h1, 32'(500 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 4'h0, 32'd0, 1'b1, 1'b0);

    // Async reset mid-stream with 5 entries and overflow set earlier.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 4'h2, 32'(600 + i), 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 32'd700, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 4'h0, 32'd0, 1'b1, 1'b0);
    check_eq("pre_reset_level", 64'(level), 64'd5);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Count wrap right after reset: first event is head and stores 0xFFFFFFFF.
    cycle(1'b1, 4'hC, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("wrap_first", 64'(ts_data), 64'({4'hC, 32'hFFFF_FFFF}));
    cycle(1'b1, 4'hD, 32'h0000_0000, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 32'd0, 1'b1, 1'b0);
`ifdef CODE_STAMP_DELTA_EN
    check_eq("wrap_second", 64'(ts_data), 64'({4'hD, 32'd1}));
`else
    check_eq("wrap_second", 64'(ts_data), 64'({4'hD, 32'd0}));
`endif
    cycle(1'b0, 4'h0, 32'd0, 1'b1, 1'b0);

    // Random traffic: slow consumer first, then a fast one.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 4'h0, 32'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
